// File: rtl/lbm_pkg.sv
// ---------------------------------------------------------------------------
// lbm_pkg: D2Q9 lattice constants, velocity lookups and moment FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package lbm_pkg;

   localparam int Q = 9;
   localparam int EX [Q] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
   localparam int EY [Q] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
   localparam logic [3:0] LAST_POP = 4'(Q - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, WRITE} moment_state_t;

   function automatic logic signed [1:0] vel_x(input logic [3:0] k);
      logic signed [1:0] v;
      v = 2'sb00;
      for (int i = 0; i < Q; i++)
         if (k == 4'(i)) v = 2'(EX[i]);
      return v;
   endfunction

   function automatic logic signed [1:0] vel_y(input logic [3:0] k);
      logic signed [1:0] v;
      v = 2'sb00;
      for (int i = 0; i < Q; i++)
         if (k == 4'(i)) v = 2'(EY[i]);
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/moment_accum.sv
// ---------------------------------------------------------------------------
// moment_accum: signed clear/add/sub/hold accumulator; saturates when MOMENT_SAT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module moment_accum #(
   parameter int W = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                add,
   input  logic                sub,
   input  logic signed [W-1:0] operand,
   output logic signed [W-1:0] next_val
);

   logic signed [W-1:0] acc_q, acc_d;

`ifdef MOMENT_SAT_EN
   logic signed [W:0] wide;

   always_comb begin
      wide = {acc_q[W-1], acc_q};
      if (add)
         wide = {acc_q[W-1], acc_q} + {operand[W-1], operand};
      else if (sub)
         wide = {acc_q[W-1], acc_q} - {operand[W-1], operand};
      // sign bits disagree only when the true result left the W-bit range
      if (clr)
         acc_d = '0;
      else if (wide[W] != wide[W-1])
         acc_d = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         acc_d = wide[W-1:0];
   end
`else
   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (add)
         acc_d = acc_q + operand;
      else if (sub)
         acc_d = acc_q - operand;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign next_val = acc_d;

endmodule
`default_nettype wire

// File: rtl/moment_calc.sv
// ---------------------------------------------------------------------------
// moment_calc: accumulates D2Q9 rho/mx/my per cell, one RAM write per cell. Option: MOMENT_SAT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module moment_calc
   import lbm_pkg::*;
#(
   parameter int DEPTH         = 16*16,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int DATA_WIDTH    = 32
)(
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] f_in,
   input  logic                         f_valid,
   output logic                         f_ready,
   output logic [ADDRESS_WIDTH-1:0]     address,
   output logic                         WE,
   output logic signed [DATA_WIDTH-1:0] rho_out,
   output logic signed [DATA_WIDTH-1:0] mx_out,
   output logic signed [DATA_WIDTH-1:0] my_out,
   output logic                         busy,
   output logic                         done
);

   moment_state_t                state_q, state_d;
   logic [3:0]                   pop_q, pop_d;
   logic [ADDRESS_WIDTH-1:0]     address_q, address_d;
   logic                         f_ready_q, f_ready_d, we_q, we_d;
   logic                         busy_q, busy_d, done_q, done_d;
   logic signed [DATA_WIDTH-1:0] rho_q, rho_d, mx_q, mx_d, my_q, my_d;
   logic signed [DATA_WIDTH-1:0] rho_nxt, mx_nxt, my_nxt;
   logic                         clr, xfer;
   logic signed [1:0]            ex, ey;

   always_comb begin
      state_d   = state_q;
      pop_d     = pop_q;
      address_d = address_q;
      done_d    = 1'b0;
      clr       = 1'b0;
      xfer      = f_valid && f_ready_q;
      ex        = vel_x(pop_q);
      ey        = vel_y(pop_q);
      rho_d     = rho_q;
      mx_d      = mx_q;
      my_d      = my_q;
      // output registers capture the completed sums so they hold until the next write
      if (xfer && pop_q == LAST_POP) begin
         rho_d = rho_nxt;
         mx_d  = mx_nxt;
         my_d  = my_nxt;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ACCUM;
               address_d = '0;
               pop_d     = '0;
               clr       = 1'b1;
            end
         end
         ACCUM: begin
            if (xfer) begin
               if (pop_q == LAST_POP) begin
                  pop_d   = '0;
                  state_d = WRITE;
               end else begin
                  pop_d = pop_q + 4'd1;
               end
            end
         end
         WRITE: begin
            clr   = 1'b1;
            pop_d = '0;
            if (address_q == ADDRESS_WIDTH'(DEPTH - 1)) begin
               address_d = '0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               address_d = address_q + ADDRESS_WIDTH'(1);
               state_d   = ACCUM;
            end
         end
         default: state_d = IDLE;
      endcase
      f_ready_d = (state_d == ACCUM);
      we_d      = (state_d == WRITE);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         pop_q     <= '0;
         address_q <= '0;
         f_ready_q <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rho_q     <= '0;
         mx_q      <= '0;
         my_q      <= '0;
      end else begin
         state_q   <= state_d;
         pop_q     <= pop_d;
         address_q <= address_d;
         f_ready_q <= f_ready_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rho_q     <= rho_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
      end
   end

   moment_accum #(.W(DATA_WIDTH)) u_rho (
      .clk(Clk), .rst_n(Reset_n), .clr(clr), .add(xfer), .sub(1'b0),
      .operand(f_in), .next_val(rho_nxt)
   );

   moment_accum #(.W(DATA_WIDTH)) u_mx (
      .clk(Clk), .rst_n(Reset_n), .clr(clr),
      .add(xfer && ex == 2'sb01), .sub(xfer && ex == 2'sb11),
      .operand(f_in), .next_val(mx_nxt)
   );

   moment_accum #(.W(DATA_WIDTH)) u_my (
      .clk(Clk), .rst_n(Reset_n), .clr(clr),
      .add(xfer && ey == 2'sb01), .sub(xfer && ey == 2'sb11),
      .operand(f_in), .next_val(my_nxt)
   );

   assign f_ready = f_ready_q;
   assign address = address_q;
   assign WE      = we_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rho_out = rho_q;
   assign mx_out  = mx_q;
   assign my_out  = my_q;

endmodule
`default_nettype wire

// File: tb/tb_moment_calc.sv
// ---------------------------------------------------------------------------
// tb_moment_calc: scoreboard bench for moment_calc (honours MOMENT_SAT_EN).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_moment_calc;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int DW    = 32;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b1;
   logic          start = 1'b0;
   logic          f_valid = 1'b0;
   logic [DW-1:0] f_in = '0;
   logic          f_ready, WE, busy, done;
   logic [AW-1:0] address;
   logic [DW-1:0] rho_out, mx_out, my_out;

   moment_calc dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .f_in(f_in), .f_valid(f_valid),
      .f_ready(f_ready), .address(address), .WE(WE), .rho_out(rho_out),
      .mx_out(mx_out), .my_out(my_out), .busy(busy), .done(done)
   );

   always #10 Clk = ~Clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] r;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad = 0;
   int            wr_cnt = 0;
   logic [DW-1:0] cf [9];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int a, input logic [DW-1:0] r, input logic [DW-1:0] x,
                       input logic [DW-1:0] y);
      exp_t e;
      e.a = AW'(a); e.r = r; e.x = x; e.y = y;
      sb.push_back(e);
   endtask

   task automatic set_seq(input int base);
      for (int k = 0; k < 9; k++) cf[k] = DW'(base + k + 1);
   endtask

   task automatic set_fill(input logic [DW-1:0] v);
      for (int k = 0; k < 9; k++) cf[k] = v;
   endtask

   // Leaves f_valid high after the final pop; the caller drops it on a later negedge.
   task automatic send_cell(input bit gappy, input int npops);
      for (int k = 0; k < npops; k++) begin
         int n;
         @(negedge Clk);
         f_valid = 1'b0;
         if (gappy) repeat ($urandom_range(0, 3)) @(negedge Clk);
         f_valid = 1'b1;
         f_in    = cf[k];
         n = 0;
         while (f_ready !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
         end
         if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got f_ready=%b expected 1 at pop %0d", f_ready, k);
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge Clk);
      f_valid = 1'b0;
      start   = 1'b1;
      @(negedge Clk);
      start   = 1'b0;
   endtask

   always @(negedge Clk) begin
      exp_t e;
      if (WE === 1'b1) begin
         wr_cnt++;
         chk("ready_in_write", {31'b0, f_ready}, 32'd0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got write at address %0d expected none", address);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", {24'b0, address}, {24'b0, e.a});
            chk("wr_rho", rho_out, e.r);
            chk("wr_mx", mx_out, e.x);
            chk("wr_my", my_out, e.y);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1 ms");
      $fatal(1);
   end

   initial begin
      int n;
      #1 Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rst_we", {31'b0, WE}, 0);
      chk("rst_ready", {31'b0, f_ready}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_addr", {24'b0, address}, 0);
      chk("rst_rho", rho_out, 0);
      Reset_n = 1'b1;

      // full frame: hand vectors first, then f_k = c+k+1 giving rho=9c+45, mx=-2, my=-6
      pulse_start();
      wr_cnt = 0;
      chk("busy_after_start", {31'b0, busy}, 1);
      set_seq(0);  push(0, 45, -2, -6); send_cell(1'b0, 9);
      set_seq(0);  push(1, 45, -2, -6); send_cell(1'b1, 9);
      set_fill(0); cf[1] = 7;  push(2, 7, 7, 0);     send_cell(1'b0, 9);
      set_fill(0); cf[7] = -4; push(3, -4, 4, 4);    send_cell(1'b1, 9);
      set_fill(0); cf[2] = 3; cf[6] = 10; push(4, 13, -10, 13); send_cell(1'b0, 9);
      for (int c = 5; c < DEPTH; c++) begin
         if (c == 100) pulse_start();
         set_seq(c);
         push(c, DW'(9 * c + 45), -2, -6);
         send_cell(1'b0, 9);
      end
      @(negedge Clk);
      f_valid = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge Clk);
         n++;
      end
      chk("done_pulse", {31'b0, done}, 1);
      chk("done_addr", {24'b0, address}, 0);
      chk("done_busy", {31'b0, busy}, 0);
      chk("frame_writes", wr_cnt, 256);
      @(negedge Clk);
      chk("done_one_cycle", {31'b0, done}, 0);

      // overflow corner
      pulse_start();
      set_fill(32'h7FFF_FFFF);
`ifdef MOMENT_SAT_EN
      push(0, 32'h7FFF_FFFF, 0, 32'h8000_0001);
`else
      push(0, 32'h7FFF_FFF7, 0, 0);
`endif
      send_cell(1'b0, 9);

      // reset after f4 of the next cell: no write, then a fresh frame
      set_seq(0);
      send_cell(1'b0, 5);
      @(negedge Clk);
      f_valid = 1'b0;
      #3 Reset_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'b0, WE}, 0);
      chk("mid_rst_ready", {31'b0, f_ready}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_addr", {24'b0, address}, 0);
      chk("mid_rst_rho", rho_out, 0);
      chk("mid_rst_mx", mx_out, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      pulse_start();
      set_seq(0); push(0, 45, -2, -6); send_cell(1'b1, 9);
      @(negedge Clk);
      f_valid = 1'b0;
      repeat (4) @(negedge Clk);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
